// File: rtl/rr_split_arbiter.sv
// rr_split_arbiter: two-master round-robin bus arbiter with split parking, grant timeout and slave notify
module rr_split_arbiter #(
  parameter int NUM_SLAVES    = 3,
  parameter int GRANT_TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_from_master,
  input  logic [1:0]              bus_utilization,
  input  logic [2*NUM_SLAVES-1:0] split_req_from_slave,
  output logic [1:0]              grant_to_master,
  output logic [2*NUM_SLAVES-1:0] notify_granted_master_to_slave,
  output logic                    busy
);
  localparam int CW = $clog2(GRANT_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, GRANTED, BUSY, RELEASE} state_t;
  state_t state, state_nx;
  logic owner, owner_nx, last, last_nx, hold_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0] blocked, eligible, grant_nx;
  always_comb begin
    blocked = '0;
    for (int s = 0; s < NUM_SLAVES; s++) blocked = blocked | split_req_from_slave[2*s +: 2];
    eligible = req_from_master & ~blocked;
  end
  // owner/last hold the bus-bit index of a master: 1 = master1, 0 = master2
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    cnt_nx   = &cnt ? cnt : cnt + 1'b1;
    case (state)
      IDLE: if (|eligible) begin
        state_nx = GRANTED;
        owner_nx = &eligible ? ~last : eligible[1];
        cnt_nx   = '0;
      end
      GRANTED: state_nx = bus_utilization[owner] ? BUSY :
                          (!req_from_master[owner] || blocked[owner] ||
                           cnt == CW'(GRANT_TIMEOUT - 1)) ? RELEASE : GRANTED;
      BUSY: state_nx = bus_utilization[owner] ? BUSY : RELEASE;
      RELEASE: begin
        state_nx = IDLE;
        last_nx  = owner;
      end
    endcase
    hold_nx  = state_nx == GRANTED || state_nx == BUSY;
    grant_nx = hold_nx ? (owner_nx ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                          <= IDLE;
      owner                          <= 1'b0;
      last                           <= 1'b0;
      cnt                            <= '0;
      grant_to_master                <= '0;
      notify_granted_master_to_slave <= '0;
      busy                           <= 1'b0;
    end else begin
      state                          <= state_nx;
      owner                          <= owner_nx;
      last                           <= last_nx;
      cnt                            <= cnt_nx;
      grant_to_master                <= grant_nx;
      notify_granted_master_to_slave <= {NUM_SLAVES{grant_nx}};
      busy                           <= hold_nx;
    end
  end
endmodule

// File: tb/tb_rr_split_arbiter.sv
// tb_rr_split_arbiter: directed and random checks of rr_split_arbiter against a transaction-level model
module tb_rr_split_arbiter;
  localparam int NS = 3;
  localparam int T  = 8;
  logic clk = 0, reset = 1;
  logic [1:0] req = 0, util = 0, grant;
  logic [2*NS-1:0] split = 0, notify;
  logic busy;
  int errors = 0, checks = 0;
  int m_own, m_age, m_cool, m_last;
  bit m_xfer;
  rr_split_arbiter #(.NUM_SLAVES(NS), .GRANT_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .req_from_master(req), .bus_utilization(util),
    .split_req_from_slave(split), .grant_to_master(grant),
    .notify_granted_master_to_slave(notify), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_own = 0; m_age = 0; m_cool = 0; m_last = 2; m_xfer = 0;
  endtask
  // m_own: 0 = nobody, 1 = master1, 2 = master2; m_cool counts the RELEASE turnaround
  task automatic model_edge();
    logic [1:0] blk, el;
    int b;
    blk = {|(split & {NS{2'b10}}), |(split & {NS{2'b01}})};
    el  = req & ~blk;
    if (m_own != 0) begin
      b = (m_own == 1) ? 1 : 0;
      if (m_xfer ? !util[b] : (!util[b] && (!req[b] || blk[b] || m_age == T - 1))) begin
        m_last = m_own; m_own = 0; m_cool = 1;
      end else if (util[b]) m_xfer = 1;
      else m_age++;
    end else if (m_cool > 0) m_cool--;
    else if (el != 0) begin
      m_own  = (el == 2'b11) ? ((m_last == 1) ? 2 : 1) : (el[1] ? 1 : 2);
      m_age  = 0;
      m_xfer = 0;
    end
  endtask
  task automatic step();
    logic [1:0] eg;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    eg = (m_own == 1) ? 2'b10 : (m_own == 2) ? 2'b01 : 2'b00;
    chk("grant", grant, eg);
    chk("notify", notify, {NS{eg}});
    chk("busy", busy, m_own != 0);
  endtask
  initial begin
    logic [1:0] seq[$];
    logic [1:0] prevg;
    logic [31:0] r;
    int gc, n1, n2, len;
    bit found;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_grant", grant, 2'b00);
    chk("reset_busy", busy, 1'b0);
    reset = 0;
    req = 2'b10;
    step();
    chk("first_grant", grant, 2'b10);
    chk("first_notify", notify, 6'b101010);
    chk("first_busy", busy, 1'b1);
    req = 2'b11;
    seq.push_back(grant);
    gc = 0;
    prevg = grant;
    for (int i = 0; i < 80 && seq.size() < 4; i++) begin
      util = (gc >= 1 && gc <= 4) ? grant : 2'b00;
      step();
      if (grant != 0 && prevg == 0) begin seq.push_back(grant); gc = 0; end
      else if (grant != 0) gc++;
      prevg = grant;
    end
    chk("alt_count", seq.size(), 4);
    for (int i = 0; i < seq.size(); i++) chk("alt_order", seq[i], (i % 2 == 0) ? 2'b10 : 2'b01);
    util = 0;
    split = 6'b001000;
    n1 = 0; n2 = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (grant == 2'b10) n1++;
      if (grant == 2'b01) n2++;
    end
    chk("split_m1_none", n1, 0);
    chk("split_m2_served", n2 > 0, 1);
    split = 0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin step(); found = grant == 2'b10; end
    chk("split_clear_m1", found, 1);
    req = 2'b01;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin step(); found = grant == 2'b01; end
    chk("timeout_granted", found, 1);
    len = 1;
    for (int i = 0; i < 20 && grant == 2'b01; i++) begin step(); if (grant == 2'b01) len++; end
    chk("timeout_len", len, T);
    chk("timeout_release", grant, 2'b00);
    step();
    chk("timeout_idle", grant, 2'b00);
    step();
    chk("timeout_regrant", grant, 2'b01);
    req = 2'b10;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin step(); found = grant == 2'b10; end
    chk("busy_m1_granted", found, 1);
    util = 2'b10;
    step();
    split = 6'b000010;
    req = 2'b11;
    repeat (3) begin step(); chk("busy_hold", grant, 2'b10); end
    util = 0;
    step();
    chk("busy_release", grant, 2'b00);
    step();
    chk("busy_idle", grant, 2'b00);
    step();
    chk("busy_m2", grant, 2'b01);
    util = 2'b01;
    step();
    #3 reset = 1;
    #1;
    chk("async_grant", grant, 2'b00);
    chk("async_notify", notify, '0);
    chk("async_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 0;
    split = 0; util = 0; req = 2'b11;
    step();
    chk("post_reset_m1", grant, 2'b10);
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      req = r[1:0];
      util = r[3:2];
      split = (r[5:4] == 2'b00) ? r[6 +: 2*NS] : '0;
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
